// File: rtl/disp_pkg.sv
// Shared constants and helpers for the display timing controller.
// Timing defaults describe 640x480@60 raster geometry.
package disp_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int PPW_DEF      = 4;

  localparam int DISP_ADDR_W  = 30;
  localparam int COORD_W      = 10;

  function automatic int ppw_log2(input int ppw);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < ppw) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_timing_ctrl_axis_counter.sv
// Compatibility alias is not used; see disp_axis_counter.sv for the counter.
// Generic wrapping counter: counts 0..LAST while en_i is high, flags LAST.
module disp_axis_counter #(
  parameter int W    = 10,
  parameter int LAST = 799
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  localparam logic [W-1:0] LAST_C = W'(LAST);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (last_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LAST_C);

endmodule

// File: rtl/disp_timing_ctrl.sv
// Raster timing generator with sticky VBLANK flag and per-frame shadowed
// framebuffer fetch pointer. All outputs are registered one cycle after hcnt/vcnt.
module disp_timing_ctrl
  import disp_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_FP         = H_FP_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_BP         = H_BP_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int V_FP         = V_FP_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_BP         = V_BP_DEF,
  parameter int PIX_PER_WORD = PPW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DISP_ADDR_W-1:0] DISPADDR,
  input  logic                   DISPON,
  input  logic                   CLRVBLNK,
  output logic                   VBLANK,
  output logic                   HSYNC_N,
  output logic                   VSYNC_N,
  output logic                   DE,
  output logic                   FETCHREQ,
  output logic [DISP_ADDR_W-1:0] FETCHADDR,
  output logic [COORD_W-1:0]     PIXX,
  output logic [COORD_W-1:0]     PIXY
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PPW_LG  = ppw_log2(PIX_PER_WORD);

  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG_C = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END_C = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] VS_BEG_C = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END_C = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] V_SET_C  = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] PIX_MASK = COORD_W'((1 << PPW_LG) - 1);

  logic [COORD_W-1:0] hcnt, vcnt;
  logic               h_last, v_last, frame_end;

  disp_axis_counter #(.W(COORD_W), .LAST(H_TOTAL - 1)) u_hcnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (1'b1),
    .cnt_o  (hcnt),
    .last_o (h_last)
  );

  disp_axis_counter #(.W(COORD_W), .LAST(V_TOTAL - 1)) u_vcnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (h_last),
    .cnt_o  (vcnt),
    .last_o (v_last)
  );

  assign frame_end = h_last & v_last;

  // ptr_q doubles as the shadowed frame base: it is loaded at the frame
  // boundary and only ever advances by whole words afterwards.
  logic                   on_q, set_q, vbl_q, de_q, hs_n_q, vs_n_q, req_q;
  logic [DISP_ADDR_W-1:0] ptr_q, fa_q;
  logic [COORD_W-1:0]     pixx_q, pixy_q;

  logic                   de_d, hs_n_d, vs_n_d, req_d, set_d, vbl_d;
  logic [DISP_ADDR_W-1:0] ptr_d, fa_d;
  logic [COORD_W-1:0]     pixx_d, pixy_d;

  always_comb begin
    de_d   = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
    hs_n_d = !((hcnt >= HS_BEG_C) && (hcnt < HS_END_C));
    vs_n_d = !((vcnt >= VS_BEG_C) && (vcnt < VS_END_C));
    req_d  = de_d && on_q && ((hcnt & PIX_MASK) == '0);
    fa_d   = req_d ? ptr_q : fa_q;
    ptr_d  = ptr_q;
    if (frame_end)  ptr_d = DISPADDR;
    else if (req_d) ptr_d = ptr_q + 1'b1;
    pixx_d = de_d ? hcnt : pixx_q;
    pixy_d = de_d ? vcnt : pixy_q;
    // Set event is staged once so VBLANK rises with the registered first blank line.
    set_d  = h_last && (vcnt == V_SET_C);
    vbl_d  = vbl_q;
    if (set_q)         vbl_d = 1'b1;
    else if (CLRVBLNK) vbl_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      on_q   <= 1'b0;
      set_q  <= 1'b0;
      vbl_q  <= 1'b0;
      de_q   <= 1'b0;
      hs_n_q <= 1'b1;
      vs_n_q <= 1'b1;
      req_q  <= 1'b0;
      ptr_q  <= '0;
      fa_q   <= '0;
      pixx_q <= '0;
      pixy_q <= '0;
    end else begin
      if (frame_end) on_q <= DISPON;
      set_q  <= set_d;
      vbl_q  <= vbl_d;
      de_q   <= de_d;
      hs_n_q <= hs_n_d;
      vs_n_q <= vs_n_d;
      req_q  <= req_d;
      ptr_q  <= ptr_d;
      fa_q   <= fa_d;
      pixx_q <= pixx_d;
      pixy_q <= pixy_d;
    end
  end

  assign VBLANK    = vbl_q;
  assign HSYNC_N   = hs_n_q;
  assign VSYNC_N   = vs_n_q;
  assign DE        = de_q;
  assign FETCHREQ  = req_q;
  assign FETCHADDR = fa_q;
  assign PIXX      = pixx_q;
  assign PIXY      = pixy_q;

endmodule

// File: tb/tb_disp_timing_ctrl.sv
// Self-checking bench for disp_timing_ctrl on a tiny 12x7 raster.
module tb_disp_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] DISPADDR;
  logic        DISPON;
  logic        CLRVBLNK;
  logic        VBLANK, HSYNC_N, VSYNC_N, DE, FETCHREQ;
  logic [29:0] FETCHADDR;
  logic [9:0]  PIXX, PIXY;

  always #5 clk = ~clk;

  disp_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_PER_WORD(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .DISPADDR  (DISPADDR),
    .DISPON    (DISPON),
    .CLRVBLNK  (CLRVBLNK),
    .VBLANK    (VBLANK),
    .HSYNC_N   (HSYNC_N),
    .VSYNC_N   (VSYNC_N),
    .DE        (DE),
    .FETCHREQ  (FETCHREQ),
    .FETCHADDR (FETCHADDR),
    .PIXX      (PIXX),
    .PIXY      (PIXY)
  );

  typedef struct {
    logic       de, hs, vs, vb, req;
    logic [29:0] fa;
    logic [9:0] px, py;
  } outs_t;

  typedef struct {
    int          cyc;
    logic [4:0]  flags;  // de, hs_n, vs_n, vblank, fetchreq
    logic [29:0] fa;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int ncyc     = 0;

  outs_t sb_q[$];

  function automatic outs_t sample();
    outs_t a;
    a.de = DE; a.hs = HSYNC_N; a.vs = VSYNC_N; a.vb = VBLANK; a.req = FETCHREQ;
    a.fa = FETCHADDR; a.px = PIXX; a.py = PIXY;
    return a;
  endfunction

  function automatic bit match(outs_t a, outs_t e);
    bit ok;
    ok = (a.de === e.de) && (a.hs === e.hs) && (a.vs === e.vs) && (a.vb === e.vb) &&
         (a.req === e.req) && (a.fa === e.fa);
    if (e.de) ok = ok && (a.px === e.px) && (a.py === e.py);
    return ok;
  endfunction

  task automatic check_outs(string name, outs_t e);
    outs_t a;
    a = sample();
    n_checks++;
    if (match(a, e)) n_pass++;
    else $display("FAIL %s cyc=%0d got de=%b hs=%b vs=%b vb=%b req=%b fa=%h x=%0d y=%0d want de=%b hs=%b vs=%b vb=%b req=%b fa=%h x=%0d y=%0d",
                  name, ncyc, a.de, a.hs, a.vs, a.vb, a.req, a.fa, a.px, a.py,
                  e.de, e.hs, e.vs, e.vb, e.req, e.fa, e.px, e.py);
  endtask

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, ncyc, act, exp);
  endtask

  task automatic wait_cyc(int n);
    int g;
    g = 0;
    while (ncyc != n && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (ncyc != n) begin
      n_checks++;
      $display("FAIL wait_cyc timeout at=%0d want=%0d", ncyc, n);
    end
  endtask

  // Reference model: closed-form raster position from the cycle count since
  // reset release; expected outputs are queued at each edge and compared on
  // the following falling edge.
  logic        m_on, m_vb;
  logic [29:0] m_base, m_fa;

  always @(posedge clk) begin
    outs_t       e;
    int          p, x, y;
    logic [29:0] fa_n;
    if (!rst) begin
      e = '{de:1'b0, hs:1'b1, vs:1'b1, vb:1'b0, req:1'b0, fa:30'h0, px:10'd0, py:10'd0};
      m_on <= 1'b0; m_vb <= 1'b0; m_base <= 30'h0; m_fa <= 30'h0;
      ncyc <= 0;
    end else begin
      p = ncyc % 84; x = p % 12; y = p / 12;
      e.de  = (x < 8) && (y < 4);
      e.hs  = !(x >= 9 && x <= 10);
      e.vs  = (y != 5);
      e.req = e.de && m_on && (x % 4 == 0);
      fa_n  = e.req ? m_base + 30'((y * 8 + x) / 4) : m_fa;
      e.fa  = fa_n;
      e.vb  = (p == 48) ? 1'b1 : (CLRVBLNK ? 1'b0 : m_vb);
      e.px  = 10'(x); e.py = 10'(y);
      m_fa <= fa_n;
      m_vb <= e.vb;
      if (p == 83) begin
        m_on   <= DISPON;
        m_base <= DISPADDR;
      end
      ncyc <= ncyc + 1;
    end
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) check_outs("scoreboard", sb_q.pop_front());
  end

  vec_t tbl[$];

  function automatic vec_t mkv(int c, logic [4:0] f, logic [29:0] fa);
    vec_t v;
    v.cyc = c; v.flags = f; v.fa = fa;
    return v;
  endfunction

  initial begin
    outs_t e;
    int    p;

    tbl.push_back(mkv(  1, 5'b11100, 30'h0));
    tbl.push_back(mkv(  5, 5'b11100, 30'h0));
    tbl.push_back(mkv(  8, 5'b11100, 30'h0));
    tbl.push_back(mkv(  9, 5'b01100, 30'h0));
    tbl.push_back(mkv( 10, 5'b00100, 30'h0));
    tbl.push_back(mkv( 11, 5'b00100, 30'h0));
    tbl.push_back(mkv( 12, 5'b01100, 30'h0));
    tbl.push_back(mkv( 13, 5'b11100, 30'h0));
    tbl.push_back(mkv( 48, 5'b01100, 30'h0));
    tbl.push_back(mkv( 49, 5'b01110, 30'h0));
    tbl.push_back(mkv( 61, 5'b01010, 30'h0));
    tbl.push_back(mkv( 72, 5'b01010, 30'h0));
    tbl.push_back(mkv( 73, 5'b01110, 30'h0));
    tbl.push_back(mkv( 85, 5'b11111, 30'h100));
    tbl.push_back(mkv( 86, 5'b11110, 30'h100));
    tbl.push_back(mkv( 89, 5'b11111, 30'h101));
    tbl.push_back(mkv(121, 5'b11111, 30'h106));
    tbl.push_back(mkv(125, 5'b11111, 30'h107));
    tbl.push_back(mkv(133, 5'b01110, 30'h107));

    rst = 1'b0; DISPON = 1'b1; DISPADDR = 30'h100; CLRVBLNK = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      wait_cyc(tbl[i].cyc);
      p = (tbl[i].cyc - 1) % 84;
      {e.de, e.hs, e.vs, e.vb, e.req} = tbl[i].flags;
      e.fa = tbl[i].fa; e.px = 10'(p % 12); e.py = 10'(p / 12);
      check_outs("table", e);
    end

    wait_cyc(134);
    CLRVBLNK = 1'b1;
    @(negedge clk);
    check_val("clr_pulse_vb", {31'd0, VBLANK}, 32'd0);
    CLRVBLNK = 1'b0;

    wait_cyc(200);
    CLRVBLNK = 1'b1;
    wait_cyc(217);
    check_val("clr_hold_set_vb", {31'd0, VBLANK}, 32'd1);
    wait_cyc(218);
    check_val("clr_hold_after_vb", {31'd0, VBLANK}, 32'd0);
    CLRVBLNK = 1'b0;

    wait_cyc(260);
    DISPADDR = 30'h200;
    wait_cyc(265);
    check_val("midframe_keep_req", {31'd0, FETCHREQ}, 32'd1);
    check_val("midframe_keep_addr", {2'b0, FETCHADDR}, 32'h102);
    wait_cyc(337);
    check_val("newframe_addr", {2'b0, FETCHADDR}, 32'h200);
    DISPADDR = 30'h3FFFFFFF;
    wait_cyc(421);
    check_val("wrap_first_addr", {2'b0, FETCHADDR}, 32'h3FFFFFFF);
    wait_cyc(425);
    check_val("wrap_second_req", {31'd0, FETCHREQ}, 32'd1);
    check_val("wrap_second_addr", {2'b0, FETCHADDR}, 32'h0);

    wait_cyc(530);
    rst = 1'b0;
    @(negedge clk);
    e = '{de:1'b0, hs:1'b1, vs:1'b1, vb:1'b0, req:1'b0, fa:30'h0, px:10'd0, py:10'd0};
    check_outs("mid_reset_outs", e);
    check_val("mid_reset_pix", {12'd0, PIXX, PIXY}, 32'd0);
    rst = 1'b1;
    DISPON = 1'b0;
    wait_cyc(1);
    check_val("restart_de", {31'd0, DE}, 32'd1);
    check_val("restart_vb", {31'd0, VBLANK}, 32'd0);
    check_val("restart_pix", {12'd0, PIXX, PIXY}, 32'd0);
    wait_cyc(85);
    check_val("dispon_off_de", {31'd0, DE}, 32'd1);
    check_val("dispon_off_req", {31'd0, FETCHREQ}, 32'd0);
    wait_cyc(180);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
